// File: rtl/sal_cfg_pkg.sv
// Shared types and constants for the boot-time APB configuration initiator:
// table entry layout, register map offsets, default timing table, FSM and
// error-code encodings.
package sal_cfg_pkg;

    localparam int CFG_ADDR_W      = 12;
    localparam int CFG_DATA_W      = 32;
    localparam int CFG_NUM_DEFAULT = 12;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } cfg_entry_t;

    // Register offsets inside the controller timing-configuration block
    localparam logic [CFG_ADDR_W-1:0] T_RCD    = 12'h000;
    localparam logic [CFG_ADDR_W-1:0] T_RP     = 12'h004;
    localparam logic [CFG_ADDR_W-1:0] T_RAS    = 12'h008;
    localparam logic [CFG_ADDR_W-1:0] T_RFC    = 12'h00C;
    localparam logic [CFG_ADDR_W-1:0] T_RTP    = 12'h010;
    localparam logic [CFG_ADDR_W-1:0] T_WTP    = 12'h014;
    localparam logic [CFG_ADDR_W-1:0] T_RRD    = 12'h018;
    localparam logic [CFG_ADDR_W-1:0] T_CCD    = 12'h01C;
    localparam logic [CFG_ADDR_W-1:0] T_WTR    = 12'h020;
    localparam logic [CFG_ADDR_W-1:0] T_RTW    = 12'h024;
    localparam logic [CFG_ADDR_W-1:0] WREN_LAT = 12'h028;
    localparam logic [CFG_ADDR_W-1:0] RDEN_LAT = 12'h02C;

    // SAL_DDR_PARAMS timing values, in controller clock cycles
    localparam logic [CFG_DATA_W-1:0] SAL_T_RCD    = 32'd4;
    localparam logic [CFG_DATA_W-1:0] SAL_T_RP     = 32'd6;
    localparam logic [CFG_DATA_W-1:0] SAL_T_RAS    = 32'd14;
    localparam logic [CFG_DATA_W-1:0] SAL_T_RFC    = 32'd52;
    localparam logic [CFG_DATA_W-1:0] SAL_T_RTP    = 32'd3;
    localparam logic [CFG_DATA_W-1:0] SAL_T_WTP    = 32'd9;
    localparam logic [CFG_DATA_W-1:0] SAL_T_RRD    = 32'd2;
    localparam logic [CFG_DATA_W-1:0] SAL_T_CCD    = 32'd8;
    localparam logic [CFG_DATA_W-1:0] SAL_T_WTR    = 32'd7;
    localparam logic [CFG_DATA_W-1:0] SAL_T_RTW    = 32'd10;
    localparam logic [CFG_DATA_W-1:0] SAL_WREN_LAT = 32'd11;
    localparam logic [CFG_DATA_W-1:0] SAL_RDEN_LAT = 32'd13;

    localparam cfg_entry_t CFG_DEFAULT_TABLE [0:CFG_NUM_DEFAULT-1] = '{
        '{addr: T_RCD,    data: SAL_T_RCD},
        '{addr: T_RP,     data: SAL_T_RP},
        '{addr: T_RAS,    data: SAL_T_RAS},
        '{addr: T_RFC,    data: SAL_T_RFC},
        '{addr: T_RTP,    data: SAL_T_RTP},
        '{addr: T_WTP,    data: SAL_T_WTP},
        '{addr: T_RRD,    data: SAL_T_RRD},
        '{addr: T_CCD,    data: SAL_T_CCD},
        '{addr: T_WTR,    data: SAL_T_WTR},
        '{addr: T_RTW,    data: SAL_T_RTW},
        '{addr: WREN_LAT, data: SAL_WREN_LAT},
        '{addr: RDEN_LAT, data: SAL_RDEN_LAT}
    };

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SLVERR   = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    typedef enum logic {
        PH_WRITE = 1'b0,
        PH_READ  = 1'b1
    } phase_t;

endpackage

// File: rtl/sal_apb_cfg_init.sv
// Boot-time APB requester: walks the timing-configuration table, writes each
// entry, optionally reads it back and compares, then reports done or error.
module sal_apb_cfg_init
    import sal_cfg_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_ENTRIES = 12,
    parameter int VERIFY      = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [5:0]        err_idx_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    if (NUM_ENTRIES < 1 || NUM_ENTRIES > 64) begin : g_bad_num_entries
        $error("sal_apb_cfg_init: NUM_ENTRIES must be in 1..64");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sal_apb_cfg_init: TIMEOUT must be at least 1");
    end

    state_t            state_reg, state_next;
    logic [5:0]        idx_reg, idx_next;
    phase_t            phase_reg, phase_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    err_code_t         err_code_reg, err_code_next;

    // Full 64-deep table so the 6-bit index never selects outside the array;
    // entries past the default table get address idx*4 with zero data.
    cfg_entry_t        tbl [0:63];
    cfg_entry_t        cur;

    for (genvar gi = 0; gi < 64; gi++) begin : g_tbl
        if (gi < CFG_NUM_DEFAULT) begin : g_dflt
            assign tbl[gi] = CFG_DEFAULT_TABLE[gi];
        end else begin : g_ext
            assign tbl[gi] = '{addr: CFG_ADDR_W'(gi * 4), data: '0};
        end
    end

    assign cur = tbl[idx_reg];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            phase_reg    <= PH_WRITE;
            tmo_reg      <= '0;
            rdata_reg    <= '0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            phase_reg    <= phase_next;
            tmo_reg      <= tmo_next;
            rdata_reg    <= rdata_next;
            err_code_reg <= err_code_next;
        end
    end

    // Next-state logic and APB drive; APB outputs decode from registers only
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        phase_next    = phase_reg;
        tmo_next      = tmo_reg;
        rdata_next    = rdata_reg;
        err_code_next = err_code_reg;
        psel_o        = 1'b0;
        penable_o     = 1'b0;
        pwrite_o      = 1'b0;
        paddr_o       = '0;
        pwdata_o      = '0;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    idx_next      = '0;
                    phase_next    = PH_WRITE;
                    tmo_next      = '0;
                    err_code_next = ERR_NONE;
                    state_next    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_o     = 1'b1;
                paddr_o    = ADDR_W'(cur.addr);
                pwrite_o   = (phase_reg == PH_WRITE);
                pwdata_o   = (phase_reg == PH_WRITE) ? DATA_W'(cur.data) : '0;
                tmo_next   = '0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                paddr_o   = ADDR_W'(cur.addr);
                pwrite_o  = (phase_reg == PH_WRITE);
                pwdata_o  = (phase_reg == PH_WRITE) ? DATA_W'(cur.data) : '0;
                if (!pready_i) begin
                    if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                        err_code_next = ERR_TIMEOUT;
                        state_next    = ST_ERR;
                    end else begin
                        tmo_next = tmo_reg + 1'b1;
                    end
                end else if (pslverr_i) begin
                    // Slave error wins over any data handling of this beat
                    err_code_next = ERR_SLVERR;
                    state_next    = ST_ERR;
                end else if (phase_reg == PH_WRITE) begin
                    if (VERIFY != 0) begin
                        phase_next = PH_READ;
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_CHECK;
                    end
                end else begin
                    rdata_next = prdata_i;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // psel low here gives the mandatory idle cycle between entries
                if (phase_reg == PH_READ && rdata_reg != DATA_W'(cur.data)) begin
                    err_code_next = ERR_MISMATCH;
                    state_next    = ST_ERR;
                end else if (idx_reg == 6'(NUM_ENTRIES - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg + 6'd1;
                    phase_next = PH_WRITE;
                    state_next = ST_SETUP;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy_o     = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS) ||
                        (state_reg == ST_CHECK);
    assign done_o     = (state_reg == ST_DONE);
    assign err_o      = (state_reg == ST_ERR);
    assign err_idx_o  = (state_reg == ST_ERR) ? idx_reg : 6'd0;
    assign err_code_o = err_code_reg;

endmodule

// File: tb/tb_sal_apb_cfg_init.sv
// Bench for sal_apb_cfg_init: two instances (write-only and write+verify)
// driven by a small APB slave model with per-entry fault injection.
module tb_sal_apb_cfg_init;

    logic        clk;
    logic        rst       [2];
    logic        start     [2];
    logic        busy      [2];
    logic        done_w    [2];
    logic        err_w     [2];
    logic [5:0]  err_idx   [2];
    logic [1:0]  err_code  [2];
    logic [11:0] paddr     [2];
    logic        psel      [2];
    logic        penable   [2];
    logic        pwrite    [2];
    logic [31:0] pwdata    [2];
    logic [31:0] prdata    [2];
    logic        pready    [2];
    logic        pslverr   [2];

    int tests = 0;
    int fails = 0;

    // Slave fault-injection knobs (entry index, -1 = none)
    int wait_entry [2];
    int wait_n     [2];
    int err_entry  [2];
    int bad_entry  [2];
    bit stuck      [2];

    int          acc_cnt [2];
    logic [31:0] mem     [2][0:63];

    typedef struct {
        int          dut;
        logic [11:0] addr;
        logic        wr;
        logic [31:0] data;
        int          len;
    } txn_t;
    txn_t txn_q[$];

    int          len_cnt [2];
    logic [11:0] su_addr [2];
    logic [31:0] su_data [2];
    logic        su_wr   [2];
    int          viol = 0;

    typedef struct {
        int          idx;
        logic [11:0] addr;
        logic [31:0] data;
    } vec_t;
    vec_t vecs [12];

    sal_apb_cfg_init #(.ADDR_W(12), .DATA_W(32), .NUM_ENTRIES(12), .VERIFY(0), .TIMEOUT(255)) dut0 (
        .clk(clk), .rst(rst[0]), .start_i(start[0]), .busy_o(busy[0]), .done_o(done_w[0]),
        .err_o(err_w[0]), .err_idx_o(err_idx[0]), .err_code_o(err_code[0]), .paddr_o(paddr[0]),
        .psel_o(psel[0]), .penable_o(penable[0]), .pwrite_o(pwrite[0]), .pwdata_o(pwdata[0]),
        .prdata_i(prdata[0]), .pready_i(pready[0]), .pslverr_i(pslverr[0])
    );

    sal_apb_cfg_init #(.ADDR_W(12), .DATA_W(32), .NUM_ENTRIES(12), .VERIFY(1), .TIMEOUT(255)) dut1 (
        .clk(clk), .rst(rst[1]), .start_i(start[1]), .busy_o(busy[1]), .done_o(done_w[1]),
        .err_o(err_w[1]), .err_idx_o(err_idx[1]), .err_code_o(err_code[1]), .paddr_o(paddr[1]),
        .psel_o(psel[1]), .penable_o(penable[1]), .pwrite_o(pwrite[1]), .pwdata_o(pwdata[1]),
        .prdata_i(prdata[1]), .pready_i(pready[1]), .pslverr_i(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave response: pready after the configured wait, error/corruption per entry
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            pready[s]  = penable[s] && !stuck[s] &&
                         (acc_cnt[s] >= ((int'(paddr[s][11:2]) == wait_entry[s]) ? wait_n[s] : 0));
            pslverr[s] = pready[s] && pwrite[s] && (int'(paddr[s][11:2]) == err_entry[s]);
            prdata[s]  = (int'(paddr[s][11:2]) == bad_entry[s]) ? (mem[s][paddr[s][7:2]] ^ 32'h1)
                                                                  : mem[s][paddr[s][7:2]];
        end
    end

    // Slave state: wait counter and register storage
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            acc_cnt[s] <= (psel[s] && penable[s] && !pready[s]) ? acc_cnt[s] + 1 : 0;
            if (psel[s] && penable[s] && pready[s] && pwrite[s])
                mem[s][paddr[s][7:2]] <= pwdata[s];
        end
    end

    // Bus monitor: transaction log, ACCESS length and protocol rules
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (penable[s] && !psel[s])
                viol <= viol + 1;
            if (psel[s] && !penable[s]) begin
                len_cnt[s] <= 0;
                su_addr[s] <= paddr[s];
                su_data[s] <= pwdata[s];
                su_wr[s]   <= pwrite[s];
            end else if (psel[s] && penable[s]) begin
                len_cnt[s] <= len_cnt[s] + 1;
                if (paddr[s] != su_addr[s] || pwdata[s] != su_data[s] || pwrite[s] != su_wr[s])
                    viol <= viol + 1;
                if (pready[s]) begin
                    txn_q.push_back('{dut: s, addr: paddr[s], wr: pwrite[s],
                                      data: pwrite[s] ? pwdata[s] : prdata[s], len: len_cnt[s] + 1});
                    $display("[TB] dut%0d %s addr=0x%03h data=0x%08h access_cycles=%0d slverr=%0d",
                             s, pwrite[s] ? "WR" : "RD", paddr[s],
                             pwrite[s] ? pwdata[s] : prdata[s], len_cnt[s] + 1, pslverr[s]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start, then wait for done/err; optional extra start pulse at cycle 'again'
    task automatic run(input int s, input int limit, input int again, output int n_end);
        n_end = -1;
        @(negedge clk);
        start[s] = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            start[s] = (n == again);
            if (done_w[s] || err_w[s]) begin
                n_end = n;
                break;
            end
        end
        start[s] = 1'b0;
    endtask

    task automatic clear_knobs();
        for (int s = 0; s < 2; s++) begin
            wait_entry[s] = -1;
            wait_n[s]     = 0;
            err_entry[s]  = -1;
            bad_entry[s]  = -1;
            stuck[s]      = 1'b0;
        end
        txn_q.delete();
    endtask

    function automatic int count_dut(input int s);
        int c = 0;
        foreach (txn_q[i]) if (txn_q[i].dut == s) c++;
        return c;
    endfunction

    initial begin
        int   n;
        int   k;
        bit   seen;
        txn_t t;

        vecs[0]  = '{0,  12'h000, 32'd4};
        vecs[1]  = '{1,  12'h004, 32'd6};
        vecs[2]  = '{2,  12'h008, 32'd14};
        vecs[3]  = '{3,  12'h00C, 32'd52};
        vecs[4]  = '{4,  12'h010, 32'd3};
        vecs[5]  = '{5,  12'h014, 32'd9};
        vecs[6]  = '{6,  12'h018, 32'd2};
        vecs[7]  = '{7,  12'h01C, 32'd8};
        vecs[8]  = '{8,  12'h020, 32'd7};
        vecs[9]  = '{9,  12'h024, 32'd10};
        vecs[10] = '{10, 12'h028, 32'd11};
        vecs[11] = '{11, 12'h02C, 32'd13};

        clear_knobs();
        for (int s = 0; s < 2; s++) begin
            rst[s]   = 1'b1;
            start[s] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_busy%0d", s), 32'(busy[s]), 0);
            check($sformatf("rst_done%0d", s), 32'(done_w[s]), 0);
            check($sformatf("rst_err%0d", s), 32'(err_w[s]), 0);
            check($sformatf("rst_psel%0d", s), 32'({psel[s], penable[s], pwrite[s]}), 0);
            check($sformatf("rst_paddr%0d", s), 32'(paddr[s]), 0);
            check($sformatf("rst_errinfo%0d", s), 32'({err_idx[s], err_code[s]}), 0);
            rst[s] = 1'b0;
        end
        @(negedge clk);

        // Zero-wait, write only: 12 writes in table order, done at cycle 37
        run(0, 200, 0, n);
        check("w0_done_cycle", 32'(n), 37);
        check("w0_done", 32'(done_w[0]), 1);
        check("w0_err", 32'(err_w[0]), 0);
        check("w0_busy", 32'(busy[0]), 0);
        check("w0_count", 32'(count_dut(0)), 12);
        k = 0;
        foreach (txn_q[i]) begin
            if (k < 12) begin
                t = txn_q[i];
                check($sformatf("w0_addr[%0d]", vecs[k].idx), 32'(t.addr), 32'(vecs[k].addr));
                check($sformatf("w0_data[%0d]", vecs[k].idx), t.data, vecs[k].data);
                check($sformatf("w0_wr[%0d]", vecs[k].idx), 32'(t.wr), 1);
            end
            k++;
        end

        // Wait states on entry 4: ACCESS stretched to 4 cycles, done 3 cycles later
        clear_knobs();
        wait_entry[0] = 4;
        wait_n[0]     = 3;
        run(0, 200, 0, n);
        check("ws_done_cycle", 32'(n), 40);
        check("ws_done", 32'(done_w[0]), 1);
        foreach (txn_q[i])
            if (txn_q[i].addr == 12'h010)
                check("ws_access_len", 32'(txn_q[i].len), 4);

        // Slave error on entry 2 write
        clear_knobs();
        err_entry[0] = 2;
        run(0, 200, 0, n);
        check("se_err", 32'(err_w[0]), 1);
        check("se_code", 32'(err_code[0]), 1);
        check("se_idx", 32'(err_idx[0]), 2);
        check("se_done", 32'(done_w[0]), 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (psel[0] || busy[0]) seen = 1'b1;
        end
        check("se_idle_after", 32'(seen), 0);

        // Verify mode, zero-wait: 24 transfers, done at cycle 61
        clear_knobs();
        run(1, 200, 0, n);
        check("v_done_cycle", 32'(n), 61);
        check("v_done", 32'(done_w[1]), 1);
        check("v_count", 32'(count_dut(1)), 24);
        k = 0;
        foreach (txn_q[i]) begin
            if (k < 24) begin
                t = txn_q[i];
                check($sformatf("v_addr[%0d]", k), 32'(t.addr), 32'(vecs[k / 2].addr));
                check($sformatf("v_data[%0d]", k), t.data, vecs[k / 2].data);
                check($sformatf("v_wr[%0d]", k), 32'(t.wr), 32'((k % 2) == 0));
            end
            k++;
        end

        // Verify mode, entry 0 reads back 0x5 instead of 0x4
        clear_knobs();
        bad_entry[1] = 0;
        run(1, 200, 0, n);
        check("mm_err", 32'(err_w[1]), 1);
        check("mm_code", 32'(err_code[1]), 2);
        check("mm_idx", 32'(err_idx[1]), 0);
        check("mm_done", 32'(done_w[1]), 0);

        // Start after an error clears the sticky error outputs
        clear_knobs();
        run(1, 200, 0, n);
        check("mm_rerun_done", 32'(done_w[1]), 1);
        check("mm_rerun_code", 32'(err_code[1]), 0);

        // pready stuck low: timeout after 255 ACCESS cycles
        clear_knobs();
        stuck[0] = 1'b1;
        run(0, 400, 0, n);
        check("to_err", 32'(err_w[0]), 1);
        check("to_code", 32'(err_code[0]), 3);
        check("to_idx", 32'(err_idx[0]), 0);
        check("to_access_len", 32'(len_cnt[0]), 255);
        check("to_end_cycle", 32'(n), 257);

        // Reset during ACCESS of entry 6, then restart from entry 0
        clear_knobs();
        wait_entry[0] = 6;
        wait_n[0]     = 10;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (psel[0] && penable[0] && paddr[0] == 12'h018) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rs_reached_e6", 32'(seen), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        check("rs_psel_drop", 32'({psel[0], penable[0]}), 0);
        check("rs_busy_drop", 32'(busy[0]), 0);
        rst[0] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (psel[0]) seen = 1'b1;
        end
        check("rs_no_autorestart", 32'(seen), 0);
        clear_knobs();
        run(0, 200, 10, n);
        check("rs_done_cycle", 32'(n), 37);
        check("rs_count", 32'(count_dut(0)), 12);
        if (txn_q.size() > 0)
            check("rs_first_addr", 32'(txn_q[0].addr), 0);
        else
            check("rs_first_addr_present", 0, 1);

        check("protocol_violations", 32'(viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
